// File: rtl/phy_seq_pkg.sv
// Shared types for the DDR PHY CSR configuration sequencer.
// Step-table record, step opcodes, FSM states and read-owner tags.
package phy_seq_pkg;

    localparam int SeqAw = 10;
    localparam int SeqDw = 32;

    typedef enum logic [1:0] {
        OP_END,
        OP_WRITE,
        OP_POLL,
        OP_WAIT
    } seq_op_e;

    typedef struct packed {
        seq_op_e          op;
        logic [SeqAw-1:0] adr;
        logic [SeqDw-1:0] data;
        logic [SeqDw-1:0] mask;
    } step_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_POLL_CHK,
        ST_WAIT,
        ST_DONE,
        ST_ERROR
    } seq_state_e;

    // Who issued the read whose data arrives next cycle.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_HOST,
        OWN_SEQ
    } rd_own_e;

endpackage

// File: rtl/phy_csr_seq.sv
// Table-driven PHY CSR bring-up sequencer plus bus arbiter (sequencer wins).
// Ports: clk_sys/rst_sys, start_i, steps_i table, host_* request/read-back,
// csr_* PHY bus, busy_o/done_o/error_o status, step_idx_o.
module phy_csr_seq
    import phy_seq_pkg::*;
#(
    parameter int AW        = 10,
    parameter int DW        = 32,
    parameter int NumSteps  = 16,
    parameter int PollLimit = 1024,
    localparam int IW       = $clog2(NumSteps)
) (
    input  logic                         clk_sys,
    input  logic                         rst_sys,
    input  logic                         start_i,
    input  step_t [NumSteps-1:0]         steps_i,
    input  logic                         host_req_i,
    input  logic                         host_we_i,
    input  logic [AW-1:0]                host_adr_i,
    input  logic [DW-1:0]                host_dat_i,
    output logic                         host_gnt_o,
    output logic                         host_rvalid_o,
    output logic [DW-1:0]                host_dat_o,
    output logic [AW-1:0]                csr_adr_o,
    output logic                         csr_we_o,
    output logic [DW-1:0]                csr_dat_w_o,
    input  logic [DW-1:0]                csr_dat_r_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         error_o,
    output logic [IW-1:0]                step_idx_o
);

    localparam int MW = $clog2(PollLimit + 1);
    localparam logic [MW-1:0] MissLast = MW'(PollLimit - 1);
    localparam logic [IW-1:0] IdxLast  = IW'(NumSteps - 1);

    seq_state_e    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [MW-1:0] miss_q, miss_d;
    rd_own_e       own_q, own_d;

    step_t cur;
    logic  advance;
    logic  poll_hit;
    logic  host_ok;

    assign cur = steps_i[idx_q];

    // Comparator only trusts data returned for the sequencer's own read.
    assign poll_hit = (own_q == OWN_SEQ) &&
        ((csr_dat_r_i & cur.mask) == (cur.data & cur.mask));

    assign host_ok = host_req_i && (state_q != ST_EXEC);

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            miss_q  <= '0;
            own_q   <= OWN_NONE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            miss_q  <= miss_d;
            own_q   <= own_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        miss_d      = miss_q;
        own_d       = OWN_NONE;
        advance     = 1'b0;
        csr_adr_o   = '0;
        csr_we_o    = 1'b0;
        csr_dat_w_o = '0;
        host_gnt_o  = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    state_d = ST_EXEC;
                    idx_d   = '0;
                    cnt_d   = '0;
                    miss_d  = '0;
                end
            end
            ST_EXEC: begin
                unique case (cur.op)
                    OP_WRITE: begin
                        csr_adr_o   = cur.adr;
                        csr_dat_w_o = cur.data;
                        csr_we_o    = 1'b1;
                        advance     = 1'b1;
                    end
                    OP_POLL: begin
                        csr_adr_o = cur.adr;
                        own_d     = OWN_SEQ;
                        state_d   = ST_POLL_CHK;
                    end
                    OP_WAIT: begin
                        cnt_d   = cur.data;
                        state_d = ST_WAIT;
                    end
                    OP_END: begin
                        state_d = ST_DONE;
                    end
                endcase
            end
            ST_POLL_CHK: begin
                if (poll_hit) begin
                    advance = 1'b1;
                end else if (miss_q == MissLast) begin
                    state_d = ST_ERROR;
                end else begin
                    miss_d  = miss_q + MW'(1);
                    state_d = ST_EXEC;
                end
            end
            ST_WAIT: begin
                // A zero count behaves like a count of one.
                if (cnt_q <= DW'(1)) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q - DW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            miss_d = '0;
            if (idx_q == IdxLast) begin
                state_d = ST_DONE;
            end else begin
                idx_d   = idx_q + IW'(1);
                state_d = ST_EXEC;
            end
        end

        // Host only ever sees the bus outside EXEC, so no overlap.
        if (host_ok) begin
            host_gnt_o  = 1'b1;
            csr_adr_o   = host_adr_i;
            csr_we_o    = host_we_i;
            csr_dat_w_o = host_dat_i;
            own_d       = host_we_i ? OWN_NONE : OWN_HOST;
        end
    end

    assign host_rvalid_o = (own_q == OWN_HOST);
    assign host_dat_o    = host_rvalid_o ? csr_dat_r_i : '0;

    assign busy_o  = (state_q == ST_EXEC) ||
                     (state_q == ST_POLL_CHK) ||
                     (state_q == ST_WAIT);
    assign done_o  = (state_q == ST_DONE);
    assign error_o = (state_q == ST_ERROR);

    assign step_idx_o = idx_q;

endmodule

// File: tb/tb_phy_csr_seq.sv
// Directed bench for phy_csr_seq: per-cycle vector tables plus
// hand-written sequences for poll timeout, reset mid-wait and table end.
module tb_phy_csr_seq;
    import phy_seq_pkg::*;

    localparam int NS = 16;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic        gnt;
        logic        rvalid;
        logic        we;
        logic [9:0]  adr;
        logic [31:0] wdat;
        logic [31:0] hdat;
        logic [3:0]  idx;
    } obs_t;

    typedef struct {
        logic        start;
        logic        hreq;
        logic        hwe;
        logic [9:0]  hadr;
        logic [31:0] hdat;
        logic [31:0] rdat;
        obs_t        exp;
    } vec_t;

    logic               clk_sys = 1'b0;
    logic               rst_sys;
    logic               start_i;
    step_t [NS-1:0]     steps;
    logic               host_req_i;
    logic               host_we_i;
    logic [9:0]         host_adr_i;
    logic [31:0]        host_dat_i;
    logic               host_gnt_o;
    logic               host_rvalid_o;
    logic [31:0]        host_dat_o;
    logic [9:0]         csr_adr_o;
    logic               csr_we_o;
    logic [31:0]        csr_dat_w_o;
    logic [31:0]        csr_dat_r_i;
    logic               busy_o;
    logic               done_o;
    logic               error_o;
    logic [3:0]         step_idx_o;

    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t tbl[$];

    always #5 clk_sys = ~clk_sys;

    phy_csr_seq #(
        .AW(10), .DW(32), .NumSteps(NS), .PollLimit(4)
    ) dut (
        .clk_sys      (clk_sys),
        .rst_sys      (rst_sys),
        .start_i      (start_i),
        .steps_i      (steps),
        .host_req_i   (host_req_i),
        .host_we_i    (host_we_i),
        .host_adr_i   (host_adr_i),
        .host_dat_i   (host_dat_i),
        .host_gnt_o   (host_gnt_o),
        .host_rvalid_o(host_rvalid_o),
        .host_dat_o   (host_dat_o),
        .csr_adr_o    (csr_adr_o),
        .csr_we_o     (csr_we_o),
        .csr_dat_w_o  (csr_dat_w_o),
        .csr_dat_r_i  (csr_dat_r_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .step_idx_o   (step_idx_o)
    );

    function automatic obs_t ob(
        input logic b, input logic d, input logic e,
        input logic g, input logic rv, input logic we,
        input logic [9:0] adr, input logic [31:0] wd,
        input logic [31:0] hd, input logic [3:0] idx);
        obs_t o;
        o.busy = b; o.done = d; o.err = e;
        o.gnt = g; o.rvalid = rv; o.we = we;
        o.adr = adr; o.wdat = wd; o.hdat = hd; o.idx = idx;
        return o;
    endfunction

    function automatic vec_t v(
        input logic st, input logic hr, input logic hw,
        input logic [9:0] ha, input logic [31:0] hd,
        input logic [31:0] rd, input obs_t e);
        vec_t r;
        r.start = st; r.hreq = hr; r.hwe = hw;
        r.hadr = ha; r.hdat = hd; r.rdat = rd; r.exp = e;
        return r;
    endfunction

    function automatic step_t mk(
        input seq_op_e op, input logic [9:0] adr,
        input logic [31:0] data, input logic [31:0] mask);
        step_t s;
        s.op = op; s.adr = adr; s.data = data; s.mask = mask;
        return s;
    endfunction

    function automatic obs_t zero_obs();
        return ob(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic chk(input string nm, input obs_t e);
        obs_t a;
        a = ob(busy_o, done_o, error_o, host_gnt_o, host_rvalid_o,
               csr_we_o, csr_adr_o, csr_dat_w_o, host_dat_o,
               step_idx_o);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle_inputs();
        start_i     = 1'b0;
        host_req_i  = 1'b0;
        host_we_i   = 1'b0;
        host_adr_i  = '0;
        host_dat_i  = '0;
        csr_dat_r_i = '0;
    endtask

    task automatic clear_steps();
        for (int i = 0; i < NS; i++) begin
            steps[i] = mk(OP_END, 0, 0, 0);
        end
    endtask

    task automatic do_reset();
        rst_sys = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk_sys);
        #1;
        rst_sys = 1'b0;
        tick();
    endtask

    task automatic run_tbl(input string nm);
        for (int i = 0; i < tbl.size(); i++) begin
            start_i     = tbl[i].start;
            host_req_i  = tbl[i].hreq;
            host_we_i   = tbl[i].hwe;
            host_adr_i  = tbl[i].hadr;
            host_dat_i  = tbl[i].hdat;
            csr_dat_r_i = tbl[i].rdat;
            #2;
            chk($sformatf("%s[%0d]", nm, i), tbl[i].exp);
            tick();
        end
        idle_inputs();
        tbl.delete();
    endtask

    initial begin
        rst_sys = 1'b1;
        idle_inputs();
        clear_steps();
        #2;
        chk("reset", zero_obs());
        do_reset();
        chk("post_reset", zero_obs());

        // Two writes then END; host read in DONE.
        clear_steps();
        steps[0] = mk(OP_WRITE, 'h010, 'hA5, 0);
        steps[1] = mk(OP_WRITE, 'h011, 'h5A, 0);
        do_reset();
        tbl.push_back(v(1, 0, 0, 0, 0, 0, zero_obs()));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,
            ob(1, 0, 0, 0, 0, 1, 'h010, 'hA5, 0, 0)));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,
            ob(1, 0, 0, 0, 0, 1, 'h011, 'h5A, 0, 1)));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,
            ob(1, 0, 0, 0, 0, 0, 0, 0, 0, 2)));
        tbl.push_back(v(0, 1, 0, 'h030, 0, 0,
            ob(0, 1, 0, 1, 0, 0, 'h030, 0, 0, 2)));
        tbl.push_back(v(0, 0, 0, 0, 0, 'hDEADBEEF,
            ob(0, 1, 0, 0, 1, 0, 0, 0, 'hDEADBEEF, 2)));
        run_tbl("wr_end");

        // Poll: two misses, hit on third read; host read in POLL_CHK.
        clear_steps();
        steps[0] = mk(OP_POLL, 'h020, 'h1, 'h1);
        do_reset();
        tbl.push_back(v(1, 0, 0, 0, 0, 0, zero_obs()));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,
            ob(1, 0, 0, 0, 0, 0, 'h020, 0, 0, 0)));
        tbl.push_back(v(0, 0, 0, 0, 0, 'hFFFFFFFE,
            ob(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,
            ob(1, 0, 0, 0, 0, 0, 'h020, 0, 0, 0)));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,
            ob(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,
            ob(1, 0, 0, 0, 0, 0, 'h020, 0, 0, 0)));
        tbl.push_back(v(0, 1, 0, 'h044, 0, 'h3,
            ob(1, 0, 0, 1, 0, 0, 'h044, 0, 0, 0)));
        tbl.push_back(v(0, 0, 0, 0, 0, 'h1234,
            ob(1, 0, 0, 0, 1, 0, 0, 0, 'h1234, 1)));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,
            ob(0, 1, 0, 0, 0, 0, 0, 0, 0, 1)));
        run_tbl("poll");

        // WAIT 5 then WRITE; host read during WAIT; start ignored.
        clear_steps();
        steps[0] = mk(OP_WAIT, 0, 5, 0);
        steps[1] = mk(OP_WRITE, 'h040, 'h77, 0);
        do_reset();
        tbl.push_back(v(1, 0, 0, 0, 0, 0, zero_obs()));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,
            ob(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(v(0, 1, 0, 'h030, 0, 0,
            ob(1, 0, 0, 1, 0, 0, 'h030, 0, 0, 0)));
        tbl.push_back(v(0, 0, 0, 0, 0, 'hCAFE,
            ob(1, 0, 0, 0, 1, 0, 0, 0, 'hCAFE, 0)));
        tbl.push_back(v(1, 0, 0, 0, 0, 0,
            ob(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,
            ob(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,
            ob(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,
            ob(1, 0, 0, 0, 0, 1, 'h040, 'h77, 0, 1)));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,
            ob(1, 0, 0, 0, 0, 0, 0, 0, 0, 2)));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,
            ob(0, 1, 0, 0, 0, 0, 0, 0, 0, 2)));
        run_tbl("wait");

        // Host write held off by three WRITE steps and END.
        clear_steps();
        steps[0] = mk(OP_WRITE, 'h100, 1, 0);
        steps[1] = mk(OP_WRITE, 'h101, 2, 0);
        steps[2] = mk(OP_WRITE, 'h102, 3, 0);
        do_reset();
        tbl.push_back(v(1, 0, 0, 0, 0, 0, zero_obs()));
        tbl.push_back(v(0, 1, 1, 'h055, 'h99, 0,
            ob(1, 0, 0, 0, 0, 1, 'h100, 1, 0, 0)));
        tbl.push_back(v(0, 1, 1, 'h055, 'h99, 0,
            ob(1, 0, 0, 0, 0, 1, 'h101, 2, 0, 1)));
        tbl.push_back(v(0, 1, 1, 'h055, 'h99, 0,
            ob(1, 0, 0, 0, 0, 1, 'h102, 3, 0, 2)));
        tbl.push_back(v(0, 1, 1, 'h055, 'h99, 0,
            ob(1, 0, 0, 0, 0, 0, 0, 0, 0, 3)));
        tbl.push_back(v(0, 1, 1, 'h055, 'h99, 0,
            ob(0, 1, 0, 1, 0, 1, 'h055, 'h99, 0, 3)));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,
            ob(0, 1, 0, 0, 0, 0, 0, 0, 0, 3)));
        run_tbl("host_wr");

        // Poll timeout after four misses, then restart clears error.
        clear_steps();
        steps[0] = mk(OP_POLL, 'h020, 'h1, 'h1);
        do_reset();
        start_i = 1'b1;
        #2;
        chk("to_c0", zero_obs());
        tick();
        start_i = 1'b0;
        repeat (7) tick();
        chk("to_c8", ob(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        start_i = 1'b1;
        #2;
        chk("to_c9", ob(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tick();
        start_i = 1'b0;
        #2;
        chk("to_c10", ob(1, 0, 0, 0, 0, 0, 'h020, 0, 0, 0));
        tick();

        // Reset mid-WAIT, then a clean restart from step 0.
        clear_steps();
        steps[0] = mk(OP_WAIT, 0, 10, 0);
        steps[1] = mk(OP_WRITE, 'h060, 'h42, 0);
        do_reset();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        host_req_i = 1'b1;
        host_adr_i = 'h030;
        tick();
        host_req_i  = 1'b0;
        host_adr_i  = '0;
        csr_dat_r_i = 'hAB;
        #1;
        chk("rw_c3", ob(1, 0, 0, 0, 1, 0, 0, 0, 'hAB, 0));
        rst_sys = 1'b1;
        #1;
        chk("rw_rst", zero_obs());
        tick();
        rst_sys     = 1'b0;
        csr_dat_r_i = '0;
        tick();
        start_i = 1'b1;
        #2;
        chk("rw_r0", zero_obs());
        tick();
        start_i = 1'b0;
        #2;
        chk("rw_r1", ob(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (10) tick();
        chk("rw_r11", ob(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk("rw_r12", ob(1, 0, 0, 0, 0, 1, 'h060, 'h42, 0, 1));
        tick();

        // Full table of writes: last index advances to DONE, no wrap.
        for (int i = 0; i < NS; i++) begin
            steps[i] = mk(OP_WRITE, 10'(('h200) + i), 32'(i), 0);
        end
        do_reset();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (15) tick();
        chk("full_c16", ob(1, 0, 0, 0, 0, 1, 'h20F, 15, 0, 15));
        tick();
        chk("full_c17", ob(0, 1, 0, 0, 0, 0, 0, 0, 0, 15));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
